// File: rtl/sha_msg_adapter.sv
// sha_msg_adapter: streams a pre-padded message in IN_W-bit words, packs them
// MSB-first into 512-bit blocks, issues each block to the SHA-256 core and
// queues the digest of every final block in an OUT_DEPTH-entry result FIFO.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_data/in_valid/in_last   message word stream; in_ready accepts a word
//   msg_data/msg_valid/msg_nxt block and one-cycle issue strobe to the core
//   msg_rdy                    core idle
//   hash_data/hash_valid       digest and one-cycle done strobe from the core
//   out_hash/out_valid/out_ready  result FIFO head
//   spurious_err               sticky: hash_valid seen when no block pending
//
// Optional feature: define SHA_ADAPT_BYTESWAP_EN to byte-reverse each input
// word before packing (little-endian sources).
module sha_msg_adapter #(
  parameter int unsigned IN_W      = 32,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [511:0]      msg_data,
  output logic              msg_valid,
  output logic              msg_nxt,
  input  logic              msg_rdy,
  input  logic [255:0]      hash_data,
  input  logic              hash_valid,
  output logic [255:0]      out_hash,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              spurious_err
);

  localparam int unsigned BLK_W  = 512;
  localparam int unsigned HASH_W = 256;
  localparam int unsigned WORDS  = BLK_W / IN_W;
  localparam int unsigned CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned PTR_W  = $clog2(OUT_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_FILL      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_HASH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [BLK_W-1:0]    buf_q, buf_d;
  logic                final_q, final_d;
  logic                first_blk_q, first_blk_d;
  logic                msg_valid_q, msg_valid_d;
  logic                msg_nxt_q, msg_nxt_d;
  logic                spurious_q, spurious_d;
  logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
  logic [HASH_W-1:0]   mem_q [OUT_DEPTH];
  logic [HASH_W-1:0]   mem_d [OUT_DEPTH];

  logic [IN_W-1:0]     word_c;
  logic [FCNT_W-1:0]   fifo_cnt_c;
  logic                fifo_room_c;
  logic                fifo_empty_c;
  logic                push_c;
  logic                pop_c;
  logic                hash_ok_c;
  logic                issue_ok_c;
  int unsigned         slot_c;

  // Input word ordering
`ifdef SHA_ADAPT_BYTESWAP_EN
  always_comb begin
    word_c = '0;
    for (int unsigned b = 0; b < IN_W / 8; b++) begin
      word_c[8*b +: 8] = in_data[IN_W-8-8*b +: 8];
    end
  end
`else
  assign word_c = in_data;
`endif

  // FIFO occupancy from wrap-bit pointers
  assign fifo_cnt_c   = wr_ptr_q - rd_ptr_q;
  assign fifo_room_c  = (fifo_cnt_c < FCNT_W'(OUT_DEPTH));
  assign fifo_empty_c = (wr_ptr_q == rd_ptr_q);

  // State-only decode; gated low while reset is asserted
  assign in_ready = rst_n && (state_q == S_FILL);

  // Block assembly, issue and hash-return FSM
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    buf_d       = buf_q;
    final_d     = final_q;
    first_blk_d = first_blk_q;
    msg_valid_d = 1'b0;
    msg_nxt_d   = 1'b0;
    spurious_d  = spurious_q;
    push_c      = 1'b0;
    slot_c      = (WORDS - 1 - 32'(count_q)) * IN_W;
    // A strobe coinciding with msg_valid is too early to belong to this block
    hash_ok_c   = hash_valid && (state_q == S_WAIT_HASH) && !msg_valid_q;
    // Final blocks reserve a FIFO slot so the later push cannot overflow
    issue_ok_c  = msg_rdy && (!final_q || fifo_room_c);

    if (hash_valid && !hash_ok_c) begin
      spurious_d = 1'b1;
    end

    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          buf_d[slot_c +: IN_W] = word_c;
          count_d = count_q + CNT_W'(1);
          if (in_last || (count_q == CNT_W'(WORDS - 1))) begin
            state_d = S_ISSUE;
            final_d = in_last;
          end
        end
      end
      S_ISSUE: begin
        if (issue_ok_c) begin
          state_d     = S_WAIT_HASH;
          msg_valid_d = 1'b1;
          msg_nxt_d   = !first_blk_q;
          first_blk_d = final_q;
        end
      end
      S_WAIT_HASH: begin
        if (hash_ok_c) begin
          state_d = S_FILL;
          push_c  = final_q;
          count_d = '0;
          buf_d   = '0;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // Result FIFO pointer/storage update
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop_c    = out_ready && !fifo_empty_c;
    if (push_c) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = hash_data;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      count_q     <= '0;
      buf_q       <= '0;
      final_q     <= 1'b0;
      first_blk_q <= 1'b1;
      msg_valid_q <= 1'b0;
      msg_nxt_q   <= 1'b0;
      spurious_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      buf_q       <= buf_d;
      final_q     <= final_d;
      first_blk_q <= first_blk_d;
      msg_valid_q <= msg_valid_d;
      msg_nxt_q   <= msg_nxt_d;
      spurious_q  <= spurious_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
    end
  end

  assign msg_data     = buf_q;
  assign msg_valid    = msg_valid_q;
  assign msg_nxt      = msg_nxt_q;
  assign spurious_err = spurious_q;
  assign out_valid    = !fifo_empty_c;
  assign out_hash     = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule
